serial_adder: RTL and testbench

- Parametrised bit-serial adder/subtractor for two WIDTH-bit operands.
- Reuses one full-adder slice plus a carry flip-flop, processing one bit per clock, LSB first.
- Sequential successor to the gate-level half adder: adds carry-in, subtract mode, overflow and a start/busy/done handshake.
- Used where area matters more than latency, as an arithmetic leaf under a controller FSM.

---
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
//==============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor, one full-adder slice per clock,
//               LSB first, with start/busy/done handshake and overflow flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_sum_bit;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_sum_nxt;

  assign w_accept    = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last      = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  // Sum bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_nxt = w_sum_bit;
    end else begin : g_wn
      assign w_sum_nxt = {w_sum_bit, r_sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      s       <= '0;
      c       <= 1'b0;
      v       <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert b here and force the initial carry.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_sum   <= '0;
      r_carry <= sub | cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        s <= w_sum_nxt;
        c <= w_carry_nxt;
        v <= r_carry ^ w_carry_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//==============================================================================
// Module      : tb_serial_adder
// Description : Randomised and directed checks of serial_adder (WIDTH 8 and 1)
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start8, cin8, sub8, busy8, done8, c8, v8;
  logic [7:0] a8, b8, s8;
  logic       start1, cin1, sub1, busy1, done1, c1, v1;
  logic [0:0] a1, b1, s1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] prev_s8 = '0;
  logic       prev_c8 = 1'b0;
  logic       prev_v8 = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sub(sub8), .busy(busy8), .done(done8), .s(s8), .c(c8), .v(v8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .sub(sub1), .busy(busy1), .done(done1), .s(s1), .c(c1), .v(v1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, req, $time);
    end
  endtask

  // Returns {v, c, s[31:0]} from plain w-bit arithmetic.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci,
                                          input logic sb);
    logic [32:0] mask, beff, sum;
    logic        cie, vv;
    mask = (33'd1 << w) - 33'd1;
    beff = sb ? (~{1'b0, y} & mask) : {1'b0, y};
    cie  = sb ? 1'b1 : ci;
    sum  = {1'b0, x} + beff + {32'b0, cie};
    vv   = (x[w-1] == beff[w-1]) && (sum[w-1] != x[w-1]);
    return {vv, sum[w], sum[31:0] & mask[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                     input logic sbi, input bit mid, input bit hold);
    logic [33:0] e;
    e      = ref_add(8, {24'b0, ai}, {24'b0, bi}, ci, sbi);
    a8     = ai;
    b8     = bi;
    cin8   = ci;
    sub8   = sbi;
    start8 = 1'b1;
    tick();
    start8 = hold;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    cin8   = 1'($urandom);
    sub8   = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      check_eq("run_hs", {busy8, done8}, 2'b10);
      check_eq("run_stable", {v8, c8, s8}, {prev_v8, prev_c8, prev_s8});
      if (mid && i == 3) start8 = 1'b1;
      else if (!hold) start8 = 1'b0;
      tick();
    end
    check_eq("done_hs", {busy8, done8}, 2'b01);
    check_eq("s8", s8, e[7:0]);
    check_eq("c8", c8, e[32]);
    check_eq("v8", v8, e[33]);
    prev_s8 = e[7:0];
    prev_c8 = e[32];
    prev_v8 = e[33];
    if (!hold) begin
      start8 = 1'b0;
      tick();
      check_eq("idle_hs", {busy8, done8}, 2'b00);
      check_eq("idle_hold", {v8, c8, s8}, {prev_v8, prev_c8, prev_s8});
    end
  endtask

  task automatic op1(input logic ai, input logic bi, input logic ci, input logic sbi);
    logic [33:0] e;
    e      = ref_add(1, {31'b0, ai}, {31'b0, bi}, ci, sbi);
    a1     = ai;
    b1     = bi;
    cin1   = ci;
    sub1   = sbi;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    a1     = 1'($urandom);
    b1     = 1'($urandom);
    cin1   = 1'($urandom);
    check_eq("w1_run", {busy1, done1}, 2'b10);
    tick();
    check_eq("w1_done", {busy1, done1}, 2'b01);
    check_eq("w1_vcs", {v1, c1, s1}, {e[33], e[32], e[0]});
    tick();
    check_eq("w1_idle", {busy1, done1}, 2'b00);
  endtask

  initial begin
    bit seen_done;
    start8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;

    // Reset with start held high
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst8_async", {busy8, done8, v8, c8, s8}, '0);
    repeat (3) tick();
    check_eq("rst8", {busy8, done8, v8, c8, s8}, '0);
    check_eq("rst1", {busy1, done1, v1, c1, s1}, '0);
    @(negedge clk);
    start8 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    repeat (3) tick();
    check_eq("post_rst8", {busy8, done8, v8, c8, s8}, '0);
    check_eq("post_rst1", {busy1, done1, v1, c1, s1}, '0);

    // Directed add / subtract cases
    op8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    op8(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);

    // Start pulse mid-run, then back-to-back accepts with start held
    op8(8'h3C, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    op8(8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1);
    op8(8'hC8, 8'h9F, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during RUN cycle 4
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    check_eq("pre_abort_busy", {busy8, done8}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_zero", {busy8, done8, v8, c8, s8}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_done |= done8;
    end
    check_eq("abort_no_done", {31'b0, seen_done}, '0);
    check_eq("abort_idle", {busy8, done8, v8, c8, s8}, '0);
    prev_s8 = '0; prev_c8 = 1'b0; prev_v8 = 1'b0;

    // WIDTH=1 exhaustive sweep, both modes
    for (int k = 0; k < 16; k++) begin
      op1(k[0], k[1], k[2], k[3]);
    end

    // Randomised operations with random handshake behaviour
    for (int k = 0; k < 30; k++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
          bit'($urandom_range(0, 1)), (k < 29) ? bit'($urandom_range(0, 1)) : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
